// File: rtl/deshifter_if.sv
// deshifter_if: serial-in / word-out bundle for the deshifter receiver.
// Latency: none; wires only.
// Backpressure: valid/ready on the word side; the serial side has no backpressure.
// With DESHIFTER_DIFF_CHECK_EN defined the bundle also carries the sin_n complement line.
// The master modport is the receiver itself; the slave modport is the link driver plus consumer.
interface deshifter_if #(parameter int WIDTH = 8);
   logic             sin;
`ifdef DESHIFTER_DIFF_CHECK_EN
   logic             sin_n;
`endif
   logic             sin_en;
   logic [WIDTH-1:0] dout;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             overrun;
   logic             frame_err;
   logic             line_err;
   logic             clr_err;

`ifdef DESHIFTER_DIFF_CHECK_EN
   modport master (
      input  sin, sin_n, sin_en, ready, clr_err,
      output dout, valid, busy, overrun, frame_err, line_err
   );
   modport slave (
      output sin, sin_n, sin_en, ready, clr_err,
      input  dout, valid, busy, overrun, frame_err, line_err
   );
`else
   modport master (
      input  sin, sin_en, ready, clr_err,
      output dout, valid, busy, overrun, frame_err, line_err
   );
   modport slave (
      output sin, sin_en, ready, clr_err,
      input  dout, valid, busy, overrun, frame_err, line_err
   );
`endif
endinterface

// File: rtl/deshifter.sv
// deshifter: LSB-first serial-to-parallel receiver with a one-word valid/ready holding register.
// Latency: dout/valid update on the edge that samples the last bit of a word.
// Backpressure: none on the serial side; a word completing into a full, unconsumed holding register is dropped and sets overrun.
// Optional feature: DESHIFTER_DIFF_CHECK_EN adds sin_n and the sticky line_err check (sin == sin_n on a sampled bit).
module deshifter #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   deshifter_if.master bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] shifted;
   logic             word_done;
   logic             frame_evt;
   logic             load;
   logic             overrun_evt;

   logic [WIDTH-1:0] dout_q;
   logic             valid_q;
   logic             overrun_q;
   logic             frame_q;

   // New bit enters at the top so the first bit of a word ends up in bit 0.
   assign shifted = {bus.sin, sr[WIDTH-1:1]};

   // Assembly state: FSM, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: start on the first qualified bit, complete on bit WIDTH-1, abort when sin_en drops mid-word.
   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      word_done = 1'b0;
      frame_evt = 1'b0;
      case (state)
         IDLE: begin
            if (bus.sin_en) begin
               sr_nxt    = shifted;
               cnt_nxt   = CW'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.sin_en) begin
               if (cnt == LAST) begin
                  // The completed word is taken straight from 'shifted'; sr restarts clean.
                  word_done = 1'b1;
                  sr_nxt    = '0;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  sr_nxt  = shifted;
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               // Partial word is discarded; the holding register is untouched.
               frame_evt = 1'b1;
               sr_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            sr_nxt    = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A completed word is accepted if the slot is empty or being drained on this same edge.
   assign load        = word_done && (!valid_q || bus.ready);
   assign overrun_evt = word_done && valid_q && !bus.ready;

   // Holding register: load on completion, clear valid on consumption.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         dout_q  <= shifted;
         valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
         valid_q <= 1'b0;
      end
   end

   // Sticky overrun/frame flags; a set event on the same edge beats clr_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         if (overrun_evt)
            overrun_q <= 1'b1;
         else if (bus.clr_err)
            overrun_q <= 1'b0;

         if (frame_evt)
            frame_q <= 1'b1;
         else if (bus.clr_err)
            frame_q <= 1'b0;
      end
   end

`ifdef DESHIFTER_DIFF_CHECK_EN
   logic line_q;
   logic line_evt;

   // Equal true/complement levels on a sampled bit indicate a broken pair; data still comes from sin.
   assign line_evt = bus.sin_en && (bus.sin == bus.sin_n);

   // Sticky line error flag; set beats clr_err.
   always_ff @(posedge clk) begin
      if (reset)
         line_q <= 1'b0;
      else if (line_evt)
         line_q <= 1'b1;
      else if (bus.clr_err)
         line_q <= 1'b0;
   end

   assign bus.line_err = line_q;
`else
   assign bus.line_err = 1'b0;
`endif

   assign bus.dout      = dout_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state == SHIFT);
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_q;

endmodule

// File: tb/tb_deshifter.sv
// tb_deshifter: directed and randomized checks of deshifter against a bit-queue reference model.
// Latency: model updates on each rising edge; comparisons happen on the falling edge.
// Backpressure: ready is driven directly by the bench, both directed and random.
module tb_deshifter;

   localparam int W = 8;

   logic clk;
   logic reset;

   deshifter_if #(.WIDTH(W)) bus ();

   deshifter #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits collected in a queue, word formed by weighting bit i with 2**i.
   bit         bits[$];
   logic [7:0] m_dout;
   logic       m_valid, m_busy, m_ovr, m_frm, m_line;
   bit         chk_en = 0;
   bit         done, f_ovr, f_frm, f_line;
   int         acc;

   always @(posedge clk) begin
      if (reset) begin
         bits.delete();
         m_dout  = 8'h00;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_frm   = 1'b0;
         m_line  = 1'b0;
      end else begin
         done   = 0;
         f_ovr  = 0;
         f_frm  = 0;
         f_line = 0;
         acc    = 0;
         if (bus.sin_en) begin
`ifdef DESHIFTER_DIFF_CHECK_EN
            if (bus.sin == bus.sin_n) f_line = 1;
`endif
            bits.push_back(bus.sin);
            if (bits.size() == W) begin
               for (int i = 0; i < W; i++) acc = acc + int'(bits[i]) * (1 << i);
               done = 1;
               bits.delete();
            end
         end else if (bits.size() != 0) begin
            f_frm = 1;
            bits.delete();
         end
         if (done) begin
            if (!m_valid || bus.ready) begin
               m_dout  = acc[7:0];
               m_valid = 1'b1;
            end else begin
               f_ovr = 1;
            end
         end else if (m_valid && bus.ready) begin
            m_valid = 1'b0;
         end
         m_ovr  = f_ovr  ? 1'b1 : (bus.clr_err ? 1'b0 : m_ovr);
         m_frm  = f_frm  ? 1'b1 : (bus.clr_err ? 1'b0 : m_frm);
         m_line = f_line ? 1'b1 : (bus.clr_err ? 1'b0 : m_line);
      end
      m_busy = (bits.size() != 0);
      chk_en = 1;
   end

   // Every cycle after the first edge, all outputs must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("dout",      32'(bus.dout),      32'(m_dout));
         check("valid",     32'(bus.valid),     32'(m_valid));
         check("busy",      32'(bus.busy),      32'(m_busy));
         check("overrun",   32'(bus.overrun),   32'(m_ovr));
         check("frame_err", 32'(bus.frame_err), 32'(m_frm));
         check("line_err",  32'(bus.line_err),  32'(m_line));
      end
   end

   task automatic drive_bit(input logic b);
      bus.sin    = b;
      bus.sin_en = 1'b1;
`ifdef DESHIFTER_DIFF_CHECK_EN
      bus.sin_n  = ~b;
`endif
   endtask

   // Drives n bits of w, LSB first, one per cycle, without dropping sin_en afterwards.
   task automatic send(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive_bit(w[i]);
      end
   endtask

   logic [15:0] pair;

   initial begin
      reset       = 1'b1;
      bus.sin     = 1'b0;
      bus.sin_en  = 1'b0;
      bus.ready   = 1'b0;
      bus.clr_err = 1'b0;
`ifdef DESHIFTER_DIFF_CHECK_EN
      bus.sin_n   = 1'b1;
`endif
      repeat (2) @(negedge clk);
      check("rst_dout",    32'(bus.dout),      32'h0);
      check("rst_valid",   32'(bus.valid),     32'h0);
      check("rst_busy",    32'(bus.busy),      32'h0);
      check("rst_overrun", 32'(bus.overrun),   32'h0);
      check("rst_frame",   32'(bus.frame_err), 32'h0);
      check("rst_line",    32'(bus.line_err),  32'h0);
      reset = 1'b0;

      // Single word 0xA5 (bits 1,0,1,0,0,1,0,1).
      send(32'hA5, 8);
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("a5_dout",  32'(bus.dout),  32'hA5);
      check("a5_model", 32'(m_dout),    32'hA5);
      check("a5_valid", 32'(bus.valid), 32'h1);
      check("a5_busy",  32'(bus.busy),  32'h0);
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      check("a5_consumed", 32'(bus.valid), 32'h0);

      // Back-to-back 0x3C then 0xC3 with ready held high.
      pair = 16'hC33C;
      bus.ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 8) begin
            check("b2b_dout0",  32'(bus.dout),  32'h3C);
            check("b2b_valid0", 32'(bus.valid), 32'h1);
         end
         if (i == 9) check("b2b_valid_drop", 32'(bus.valid), 32'h0);
         drive_bit(pair[i]);
      end
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("b2b_dout1",   32'(bus.dout),    32'hC3);
      check("b2b_valid1",  32'(bus.valid),   32'h1);
      check("b2b_overrun", 32'(bus.overrun), 32'h0);
      @(negedge clk);
      bus.ready = 1'b0;

      // Overrun: 0x11 then 0x22 with nobody consuming.
      send(32'h2211, 16);
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("ovr_dout",  32'(bus.dout),    32'h11);
      check("ovr_model", 32'(m_dout),      32'h11);
      check("ovr_flag",  32'(bus.overrun), 32'h1);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      check("ovr_cleared", 32'(bus.overrun), 32'h0);
      check("ovr_kept",    32'(bus.dout),    32'h11);

      // Consume on the same edge as the second word completes.
      send(32'h22, 7);
      @(negedge clk);
      drive_bit(1'b0);
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready  = 1'b0;
      bus.sin_en = 1'b0;
      check("same_dout",    32'(bus.dout),    32'h22);
      check("same_valid",   32'(bus.valid),   32'h1);
      check("same_overrun", 32'(bus.overrun), 32'h0);

      // Truncation after 5 bits; held word must survive.
      send(32'h1F, 5);
      @(negedge clk);
      bus.sin_en = 1'b0;
      @(negedge clk);
      check("trunc_frame", 32'(bus.frame_err), 32'h1);
      check("trunc_busy",  32'(bus.busy),      32'h0);
      check("trunc_valid", 32'(bus.valid),     32'h1);
      check("trunc_dout",  32'(bus.dout),      32'h22);
      bus.ready   = 1'b1;
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.ready   = 1'b0;
      bus.clr_err = 1'b0;
      send(32'h5A, 8);
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("after_trunc_dout", 32'(bus.dout), 32'h5A);

      // Reset in the middle of a word.
      send(32'h7, 3);
      @(negedge clk);
      bus.sin_en = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_dout",  32'(bus.dout),      32'h0);
      check("mid_rst_valid", 32'(bus.valid),     32'h0);
      check("mid_rst_busy",  32'(bus.busy),      32'h0);
      check("mid_rst_frame", 32'(bus.frame_err), 32'h0);

`ifdef DESHIFTER_DIFF_CHECK_EN
      // 0xFF with the complement line stuck equal on bit 3.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_bit(1'b1);
         if (i == 3) bus.sin_n = 1'b1;
      end
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("diff_line", 32'(bus.line_err), 32'h1);
      check("diff_dout", 32'(bus.dout),     32'hFF);
      bus.ready   = 1'b1;
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.ready   = 1'b0;
      bus.clr_err = 1'b0;
      check("diff_cleared", 32'(bus.line_err), 32'h0);
`else
      send(32'hFF, 8);
      @(negedge clk);
      bus.sin_en = 1'b0;
      check("noline_dout", 32'(bus.dout),     32'hFF);
      check("noline_flag", 32'(bus.line_err), 32'h0);
`endif

      // Randomized traffic; the per-cycle compare against the model does the checking.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.sin     = 1'($urandom_range(0, 1));
         bus.sin_en  = ($urandom_range(0, 7) != 0);
         bus.ready   = ($urandom_range(0, 2) == 0);
         bus.clr_err = ($urandom_range(0, 31) == 0);
         reset       = ($urandom_range(0, 499) == 0);
`ifdef DESHIFTER_DIFF_CHECK_EN
         bus.sin_n   = ($urandom_range(0, 15) == 0) ? bus.sin : ~bus.sin;
`endif
      end
      @(negedge clk);
      bus.sin_en  = 1'b0;
      bus.ready   = 1'b0;
      bus.clr_err = 1'b0;
      reset       = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
